// File: rtl/core_pkg.sv
// Shared definitions for the memory/write-back stage: control-word layout,
// access sizes and the store lane-steering helper.
package core_pkg;

    localparam int CONTROL_BIT = 7;
    localparam int MEM_READ    = 0;
    localparam int MEM_WRITE   = 1;
    localparam int REG_WRITE   = 2;
    localparam int WB_SEL      = 3;   // 1 selects PC+4 (JAL/JALR)
    localparam int FUNCT3_LSB  = 4;
    localparam int FUNCT3_MSB  = 6;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_e;
    typedef enum logic [1:0] {BYTE, HALF, WORD} mem_size_e;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
    } store_lane_t;

    function automatic mem_size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return BYTE;
            F3_LH, F3_LHU: return HALF;
            default:       return WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] addr, input mem_size_e size);
        case (size)
            BYTE:    return 1'b0;
            HALF:    return addr[0];
            default: return addr != 2'b00;
        endcase
    endfunction

    // Mirror of load_align: steer store data into its byte lanes.
    function automatic store_lane_t store_align(input logic [31:0] data, input logic [1:0] addr,
                                                input mem_size_e size);
        store_lane_t s;
        case (size)
            BYTE: begin
                s.be    = 4'b0001 << addr;
                s.wdata = {4{data[7:0]}};
            end
            HALF: begin
                s.be    = 4'b0011 << addr;
                s.wdata = {2{data[15:0]}};
            end
            default: begin
                s.be    = 4'hF;
                s.wdata = data;
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from a bus read word and
// sign- or zero-extends it to 32 bits.
module load_align
    import core_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  mem_size_e   size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [31:0] sh;
    assign sh = rdata_i >> {addr_i, 3'b000};

    always_comb begin
        data_o = rdata_i;
        case (size_i)
            BYTE:    data_o = {{24{~unsigned_i & sh[7]}}, sh[7:0]};
            HALF:    data_o = {{16{~unsigned_i & sh[15]}}, sh[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage: executes loads/stores over a req/gnt/rvalid bus
// and drives the register-file write-back port.
module mem_wb_stage
    import core_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255,
    parameter int XLEN        = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [CONTROL_BIT-1:0] mem_control_i,
    input  logic [XLEN-1:0]        mem_aluResult_i,
    input  logic [XLEN-1:0]        mem_data_i,
    input  logic [XLEN-1:0]        mem_rd_addr_i,
    input  logic [XLEN-1:0]        mem_pcplus_i,
    output logic                   mem_ready_o,
    output logic                   dmem_req_o,
    output logic                   dmem_we_o,
    output logic [XLEN-1:0]        dmem_addr_o,
    output logic [3:0]             dmem_be_o,
    output logic [XLEN-1:0]        dmem_wdata_o,
    input  logic                   dmem_gnt_i,
    input  logic                   dmem_rvalid_i,
    input  logic [XLEN-1:0]        dmem_rdata_i,
    output logic [4:0]             wb_rd_addr_o,
    output logic [XLEN-1:0]        wb_rd_o,
    output logic                   wb_rd_en_o,
    output logic                   misalign_o,
    output logic                   bus_err_o
);

    mem_state_e  state_q;
    logic [31:0] cnt_q;
    logic [31:0] addr_q, wdata_q, wb_rd_q;
    logic [3:0]  be_q;
    logic [4:0]  rd_q, wb_rd_addr_q;
    mem_size_e   size_q;
    logic        uns_q, we_q, regwr_q;
    logic        wb_rd_en_q, misalign_q, bus_err_q;

    logic [2:0]  f3;
    mem_size_e   in_size;
    logic        is_mem, timeout;
    store_lane_t st;
    logic [31:0] ld_data;
    logic        unused_hi;

    assign f3        = mem_control_i[FUNCT3_MSB:FUNCT3_LSB];
    assign in_size   = f3_size(f3);
    assign is_mem    = mem_control_i[MEM_READ] | mem_control_i[MEM_WRITE];
    assign st        = store_align(mem_data_i, mem_aluResult_i[1:0], in_size);
    assign timeout   = (BUS_TIMEOUT != 0) && (cnt_q == 32'(BUS_TIMEOUT - 1));
    assign unused_hi = ^mem_rd_addr_i[XLEN-1:5];

    load_align u_load_align (
        .rdata_i    (dmem_rdata_i),
        .addr_i     (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (ld_data)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            rd_q         <= '0;
            size_q       <= BYTE;
            uns_q        <= 1'b0;
            we_q         <= 1'b0;
            regwr_q      <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_rd_q      <= '0;
            wb_rd_en_q   <= 1'b0;
            misalign_q   <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            wb_rd_en_q <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (is_mem) begin
                        if (misaligned(mem_aluResult_i[1:0], in_size)) begin
                            misalign_q <= 1'b1;
                        end else begin
                            addr_q  <= mem_aluResult_i;
                            wdata_q <= st.wdata;
                            be_q    <= mem_control_i[MEM_WRITE] ? st.be : 4'hF;
                            rd_q    <= mem_rd_addr_i[4:0];
                            size_q  <= in_size;
                            uns_q   <= f3[2];
                            we_q    <= mem_control_i[MEM_WRITE];
                            regwr_q <= mem_control_i[REG_WRITE];
                            state_q <= REQ;
                        end
                    end else if (mem_control_i[REG_WRITE]) begin
                        wb_rd_addr_q <= mem_rd_addr_i[4:0];
                        wb_rd_q      <= mem_control_i[WB_SEL] ? mem_pcplus_i : mem_aluResult_i;
                        wb_rd_en_q   <= mem_rd_addr_i[4:0] != 5'd0;
                    end
                end
                REQ: begin
                    if (dmem_gnt_i) begin
                        cnt_q   <= '0;
                        state_q <= we_q ? IDLE : RESP;
                    end else if (timeout) begin
                        cnt_q     <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                RESP: begin
                    if (dmem_rvalid_i) begin
                        cnt_q        <= '0;
                        wb_rd_addr_q <= rd_q;
                        wb_rd_q      <= ld_data;
                        wb_rd_en_q   <= regwr_q && (rd_q != 5'd0);
                        state_q      <= IDLE;
                    end else if (timeout) begin
                        cnt_q     <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_ready_o  = (state_q == IDLE);
    assign dmem_req_o   = (state_q == REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign wb_rd_addr_o = wb_rd_addr_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_rd_en_o   = wb_rd_en_q;
    assign misalign_o   = misalign_q;
    assign bus_err_o    = bus_err_q;

endmodule
